// File: rtl/ecdsa_pkg.sv
// ---------------------------------------------------------------------------
// ecdsa_pkg
//   Shared definitions for the ECDSA datapath blocks.
//   - FSM state encoding for the modular inverter (IDLE, RUN)
//   - secp256k1 field prime P and group order N
// ---------------------------------------------------------------------------
package ecdsa_pkg;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [255:0] SECP256K1_P =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [255:0] SECP256K1_N =
        256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_BAAEDCE6_AF48A03B_BFD25E8C_D0364141;

endpackage

// File: rtl/mod_halve.sv
// ---------------------------------------------------------------------------
// mod_halve
//   Combinational modular halving: o_half = i_x / 2 mod i_m, for odd i_m
//   and i_x in [0, i_m).
//   Ports:
//     i_x    [WIDTH-1:0]  value to halve
//     i_m    [WIDTH-1:0]  odd modulus
//     o_half [WIDTH-1:0]  i_x * 2^-1 mod i_m
// ---------------------------------------------------------------------------
module mod_halve #(
    parameter int WIDTH = 256
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_m,
    output logic [WIDTH-1:0] o_half
);

    // An odd x becomes even by adding the odd modulus; the sum can carry
    // out of WIDTH bits, so it is formed one bit wider before the shift.
    logic [WIDTH:0] w_sum;

    assign w_sum  = i_x[0] ? ({1'b0, i_x} + {1'b0, i_m}) : {1'b0, i_x};
    assign o_half = w_sum[WIDTH:1];

endmodule

// File: rtl/mod_inv_param.sv
// ---------------------------------------------------------------------------
// mod_inv_param
//   Modular inverse result = a^-1 mod m by binary extended Euclid,
//   one iteration per clock, with start/done/busy handshake, error
//   reporting for non-invertible operands and an iteration watchdog.
//   Ports:
//     clk     clock, rising edge
//     rst_n   asynchronous active-low reset
//     start   request, sampled only while busy=0
//     a, m    operand and modulus, sampled on the accepting edge
//     result  inverse (0 on error), held until the next done
//     done    one-cycle completion pulse
//     err     operation failed, cleared on the next accept
//     busy    operation in progress
// ---------------------------------------------------------------------------
module mod_inv_param
    import ecdsa_pkg::*;
#(
    parameter int WIDTH    = 256,
    parameter int MAX_ITER = 2*WIDTH+2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] m,
    output logic [WIDTH-1:0] result,
    output logic             done,
    output logic             err,
    output logic             busy
);

    localparam int               IW         = $clog2(MAX_ITER+1);
    localparam logic [WIDTH-1:0] ONE        = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [IW-1:0]    ITER_LIMIT = IW'(MAX_ITER);

    logic [0:0]       r_state;
    logic [WIDTH-1:0] r_u;
    logic [WIDTH-1:0] r_v;
    logic [WIDTH-1:0] r_x1;
    logic [WIDTH-1:0] r_x2;
    logic [WIDTH-1:0] r_m;
    logic [IW-1:0]    r_iter;
    logic             r_bad;
    logic [WIDTH-1:0] r_result;
    logic             r_done;
    logic             r_err;
    logic             r_busy;

    logic             w_bad_in;
    logic             w_fail;
    logic [WIDTH-1:0] w_x1_half;
    logic [WIDTH-1:0] w_x2_half;
    logic [WIDTH-1:0] w_x1_sub;
    logic [WIDTH-1:0] w_x2_sub;
    logic [WIDTH-1:0] w_x1_diff;
    logic [WIDTH-1:0] w_x2_diff;

    // Operand checks that depend only on a/m are folded into one flag at
    // accept time, so later changes on a/m cannot influence the run.
    assign w_bad_in = ~m[0] | (m <= ONE) | (a == '0) | (a >= m);

    assign w_fail = r_bad | (r_u == '0) | (r_v == '0) | (r_iter == ITER_LIMIT);

    mod_halve #(.WIDTH(WIDTH)) u_halve_x1 (
        .i_x    (r_x1),
        .i_m    (r_m),
        .o_half (w_x1_half)
    );

    mod_halve #(.WIDTH(WIDTH)) u_halve_x2 (
        .i_x    (r_x2),
        .i_m    (r_m),
        .o_half (w_x2_half)
    );

    // Differences wrap modulo 2^WIDTH; adding m back on a borrow lands the
    // wrapped value in [0, m).
    assign w_x1_sub  = r_x1 - r_x2;
    assign w_x2_sub  = r_x2 - r_x1;
    assign w_x1_diff = (r_x1 < r_x2) ? (w_x1_sub + r_m) : w_x1_sub;
    assign w_x2_diff = (r_x2 < r_x1) ? (w_x2_sub + r_m) : w_x2_sub;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_u      <= '0;
            r_v      <= '0;
            r_x1     <= '0;
            r_x2     <= '0;
            r_m      <= '0;
            r_iter   <= '0;
            r_bad    <= 1'b0;
            r_result <= '0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (r_state == ST_IDLE) begin
                if (start) begin
                    r_u     <= a;
                    r_v     <= m;
                    r_x1    <= ONE;
                    r_x2    <= '0;
                    r_m     <= m;
                    r_iter  <= '0;
                    r_bad   <= w_bad_in;
                    r_err   <= 1'b0;
                    r_busy  <= 1'b1;
                    r_state <= ST_RUN;
                end
            end else begin
                if (w_fail || (r_u == ONE) || (r_v == ONE)) begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= ST_IDLE;
                    r_err   <= w_fail;
                    if (w_fail) begin
                        r_result <= '0;
                    end else if (r_u == ONE) begin
                        r_result <= r_x1;
                    end else begin
                        r_result <= r_x2;
                    end
                end else begin
                    // Halving steps on u and v are independent and may
                    // both fire; subtraction only when both are odd.
                    if (!r_u[0]) begin
                        r_u  <= r_u >> 1;
                        r_x1 <= w_x1_half;
                    end
                    if (!r_v[0]) begin
                        r_v  <= r_v >> 1;
                        r_x2 <= w_x2_half;
                    end
                    if (r_u[0] && r_v[0]) begin
                        if (r_u >= r_v) begin
                            r_u  <= r_u - r_v;
                            r_x1 <= w_x1_diff;
                        end else begin
                            r_v  <= r_v - r_u;
                            r_x2 <= w_x2_diff;
                        end
                    end
                    r_iter <= r_iter + 1'b1;
                end
            end
        end
    end

    assign result = r_result;
    assign done   = r_done;
    assign err    = r_err;
    assign busy   = r_busy;

endmodule

// File: tb/tb_mod_inv_param.sv
// ---------------------------------------------------------------------------
// tb_mod_inv_param
//   Self-checking bench for mod_inv_param: a 256-bit instance and an 8-bit
//   instance share clock, reset and start. Expected values come from a
//   behavioural model (classical extended Euclid for the inverse, an
//   integer walk of the binary algorithm for the iteration count).
// ---------------------------------------------------------------------------
module tb_mod_inv_param;
    import ecdsa_pkg::*;

    localparam int W      = 256;
    localparam int W8     = 8;
    localparam int MAXIT  = 2*W+2;
    localparam int MAXIT8 = 2*W8+2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         start;
    logic [255:0] a, m, result;
    logic         done, err, busy;
    logic [7:0]   a8, m8, result8;
    logic         done8, err8, busy8;

    int n_total = 0;
    int n_bad   = 0;

    logic [255:0] exp_res, exp_res8;
    bit           exp_err, exp_err8, use8;
    int           exp_n, exp_n8;

    always #5 clk = ~clk;

    mod_inv_param #(.WIDTH(W)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a), .m(m),
        .result(result), .done(done), .err(err), .busy(busy)
    );

    mod_inv_param #(.WIDTH(W8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start), .a(a8), .m(m8),
        .result(result8), .done(done8), .err(err8), .busy(busy8)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] want);
        n_total++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, want);
        end
    endtask

    // Reference: error rules, iteration count of the binary walk, and the
    // inverse from the classical (division based) extended Euclid.
    function automatic void ref_inv(input logic [255:0] av, input logic [255:0] mv,
                                    input int maxit, output logic [255:0] res,
                                    output bit e, output int n);
        logic [255:0] u, v;
        logic [511:0] r0, r1, t0, t1, q, tmp, mw;
        n = 0; e = 1'b0; res = '0;
        if (mv[0] == 1'b0 || mv <= 1 || av == 0 || av >= mv) begin
            e = 1'b1;
            return;
        end
        u = av; v = mv;
        forever begin
            if (u == 0 || v == 0 || n == maxit) begin
                e = 1'b1;
                return;
            end
            if (u == 1 || v == 1) break;
            if (u[0] && v[0]) begin
                if (u >= v) u = u - v;
                else        v = v - u;
            end else begin
                if (!u[0]) u = u >> 1;
                if (!v[0]) v = v >> 1;
            end
            n++;
        end
        mw = {256'b0, mv};
        r0 = mw; r1 = {256'b0, av}; t0 = '0; t1 = 512'd1;
        while (r1 != 0) begin
            q   = r0 / r1;
            tmp = r0 - q * r1;
            r0  = r1;
            r1  = tmp;
            tmp = (t0 + mw - (q * t1) % mw) % mw;
            t0  = t1;
            t1  = tmp;
        end
        res = t0[255:0];
    endfunction

    task automatic await_done(input string tag, input bit poke,
                              input logic [255:0] prev, input logic [7:0] prev8,
                              input logic [255:0] av, input logic [255:0] mv);
        int lat = 0, lat8 = 0;
        bit got = 1'b0, got8, ok = 1'b1, ok8 = 1'b1;
        logic [511:0] prod;
        got8 = !use8;
        for (int k = 1; k <= MAXIT + 4; k++) begin
            if (got && got8) break;
            if (poke && k == 2) begin
                start = 1'b1; a = av + 256'd2; m = mv + 256'd2; a8 = a[7:0]; m8 = m[7:0];
            end
            if (poke && k == 3) start = 1'b0;
            @(posedge clk); #1;
            if (!got) begin
                if (done) begin got = 1'b1; lat = k; end
                else if (!busy || result !== prev) ok = 1'b0;
            end
            if (!got8) begin
                if (done8) begin got8 = 1'b1; lat8 = k; end
                else if (!busy8 || result8 !== prev8) ok8 = 1'b0;
            end
        end
        chk({tag, "/busy_run"}, ok, 1);
        chk({tag, "/latency"}, lat, 1 + exp_n);
        chk({tag, "/lat_bound"}, (lat >= 1 && lat <= MAXIT + 1), 1);
        chk({tag, "/result"}, result, exp_res);
        chk({tag, "/err"}, err, exp_err);
        chk({tag, "/busy_fin"}, busy, 0);
        if (got && !exp_err) begin
            prod = ({256'b0, av} * {256'b0, result}) % {256'b0, mv};
            chk({tag, "/a_x_inv"}, prod[255:0], 1);
        end
        if (use8) begin
            chk({tag, "/busy_run8"}, ok8, 1);
            chk({tag, "/latency8"}, lat8, 1 + exp_n8);
            chk({tag, "/result8"}, result8, exp_res8);
            chk({tag, "/err8"}, err8, exp_err8);
        end
    endtask

    task automatic run_op(input string tag, input logic [255:0] av, input logic [255:0] mv,
                          input bit hold, input bit poke);
        logic [255:0] pr;
        logic [7:0]   pr8;
        use8 = (mv < 256);
        ref_inv(av, mv, MAXIT, exp_res, exp_err, exp_n);
        if (use8) ref_inv(av, mv, MAXIT8, exp_res8, exp_err8, exp_n8);
        @(negedge clk);
        a = av; m = mv; a8 = av[7:0]; m8 = mv[7:0]; start = 1'b1;
        pr = result; pr8 = result8;
        @(posedge clk); #1;
        chk({tag, "/busy_acc"}, busy, 1);
        chk({tag, "/err_clr"}, err, 0);
        if (use8) chk({tag, "/busy_acc8"}, busy8, 1);
        if (!hold) start = 1'b0;
        await_done(tag, poke, pr, pr8, av, mv);
        @(posedge clk); #1;
        chk({tag, "/done_pulse"}, done, 0);
        if (hold) begin
            chk({tag, "/reaccept"}, busy, 1);
            start = 1'b0;
            await_done({tag, "_2"}, 1'b0, exp_res, exp_res8[7:0], av, mv);
        end
    endtask

    function automatic logic [255:0] rand256();
        logic [255:0] r;
        for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom();
        return r;
    endfunction

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [255:0] p, n, rv, mv;
        bit seen;
        p = SECP256K1_P;
        n = SECP256K1_N;
        start = 1'b0; a = '0; m = '0; a8 = '0; m8 = '0; rst_n = 1'b0;
        #2;
        chk("rst/result", result, 0);
        chk("rst/done",   done,   0);
        chk("rst/err",    err,    0);
        chk("rst/busy",   busy,   0);
        chk("rst/busy8",  busy8,  0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        run_op("inv3_7",  256'd3, 256'd7,  1'b0, 1'b0);
        chk("inv3_7/val", result, 5);
        run_op("a1_m97",  256'd1, 256'd97, 1'b0, 1'b0);
        run_op("gcd3",    256'd6, 256'd15, 1'b0, 1'b0);
        run_op("even_m",  256'd3, 256'd16, 1'b0, 1'b0);
        run_op("half_p",  256'd2, p,       1'b0, 1'b0);
        chk("half_p/val", result, (p + 256'd1) >> 1);
        run_op("poke",    256'd3, 256'd97, 1'b0, 1'b1);
        run_op("hold",    256'd3, 256'd7,  1'b1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            mv = 256'($urandom_range(3, 255) | 1);
            rv = 256'($urandom_range(0, 32'(mv) + 1));
            run_op($sformatf("small%0d", i), rv, mv, 1'b0, 1'b0);
        end
        for (int i = 0; i < 3; i++) begin
            rv = rand256();
            if (rv >= p) rv = rv - p;
            if (rv == 0) rv = 256'd5;
            run_op($sformatf("randp%0d", i), rv, p, 1'b0, 1'b0);
        end
        for (int i = 0; i < 2; i++) begin
            rv = rand256();
            if (rv >= n) rv = rv - n;
            if (rv == 0) rv = 256'd9;
            run_op($sformatf("randn%0d", i), rv, n, 1'b0, 1'b0);
        end

        // Reset in the middle of a long 256-bit run.
        run_op("pre_rst", 256'd5, 256'd7, 1'b0, 1'b0);
        @(negedge clk);
        rv = rand256();
        if (rv >= p) rv = rv - p;
        a = rv; m = p; a8 = rv[7:0]; m8 = p[7:0]; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid/busy", busy, 1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst/busy",    busy,    0);
        chk("mid_rst/done",    done,    0);
        chk("mid_rst/err",     err,     0);
        chk("mid_rst/result",  result,  0);
        chk("mid_rst/result8", result8, 0);
        seen = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
            if (done || done8) seen = 1'b1;
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done || done8 || busy) seen = 1'b1;
        end
        chk("mid_rst/no_done", seen, 0);
        run_op("post_rst", 256'd3, 256'd7, 1'b0, 1'b0);
        chk("post_rst/val", result, 5);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
